// File: rtl/meter_ctrl_if.sv
// Button and display bus for the coin meter.
// master drives buttons; slave (the meter) drives display values.
interface meter_ctrl_if;
    logic        coin1;
    logic        coin5;
    logic        start;
    logic        cancel;
    logic [19:0] TimeLeft;
    logic [19:0] Money;
    logic        busy;
    logic        done;

    modport master (
        output coin1, coin5, start, cancel,
        input  TimeLeft, Money, busy, done
    );

    modport slave (
        input  coin1, coin5, start, cancel,
        output TimeLeft, Money, busy, done
    );
endinterface

// File: rtl/meter_ctrl.sv
// Coin-operated timed-service controller.
// Money buys seconds, counted down at one tick per TICK_DIV clocks.
module meter_ctrl #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int SEC_PER_UNIT = 2,
    parameter int MAX_VAL      = 99,
    parameter int DONE_HOLD    = 3
) (
    input  logic        clk,
    input  logic        rst,
    meter_ctrl_if.slave bus
);
    localparam int AW = 16;
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(DONE_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cur;
    logic [3:0]    r_prev;
    logic [TW-1:0] r_tick_cnt;
    logic [HW-1:0] r_hold;
    logic [6:0]    r_tl;
    logic [6:0]    r_money;
    logic          r_busy;
    logic          r_done;

    logic [3:0]    w_ev;
    logic          w_coin;
    logic          w_tick;
    logic [AW-1:0] w_add;
    logic [AW-1:0] w_money_sum;
    logic [6:0]    w_money_sat;
    logic [AW-1:0] w_idle_raw;
    logic [6:0]    w_idle_tl;
    logic [AW-1:0] w_run_sum;
    logic [AW-1:0] w_run_raw;
    logic [6:0]    w_run_tl;

    // Event decode and saturating next-value arithmetic (bits: cancel,start,coin5,coin1)
    always_comb begin
        w_ev        = r_cur & ~r_prev;
        w_coin      = w_ev[0] | w_ev[1];
        w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
        w_add       = (w_ev[0] ? AW'(1) : AW'(0))
                    + (w_ev[1] ? AW'(5) : AW'(0));
        w_money_sum = AW'(r_money) + w_add;
        w_money_sat = (w_money_sum > AW'(MAX_VAL))
                    ? 7'(MAX_VAL) : w_money_sum[6:0];
        w_idle_raw  = AW'(w_money_sat) * AW'(SEC_PER_UNIT);
        w_idle_tl   = (w_idle_raw > AW'(MAX_VAL))
                    ? 7'(MAX_VAL) : w_idle_raw[6:0];
        w_run_sum   = AW'(r_tl) + w_add * AW'(SEC_PER_UNIT);
        // Decrement before clamping so a top-up at the ceiling still loses the tick
        w_run_raw   = (w_tick && w_run_sum != '0)
                    ? w_run_sum - AW'(1) : w_run_sum;
        w_run_tl    = (w_run_raw > AW'(MAX_VAL))
                    ? 7'(MAX_VAL) : w_run_raw[6:0];
    end

    // Button sampling, state machine and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_prev     <= '0;
            r_tick_cnt <= '0;
            r_hold     <= '0;
            r_tl       <= '0;
            r_money    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_prev <= r_cur;
            r_cur  <= {bus.cancel, bus.start, bus.coin5, bus.coin1};
            unique case (r_state)
                S_IDLE: begin
                    r_tick_cnt <= '0;
                    r_hold     <= '0;
                    if (w_ev[3]) begin
                        r_money <= '0;
                        r_tl    <= '0;
                    end else if (w_ev[2] && r_money != '0) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else if (w_coin) begin
                        r_money <= w_money_sat;
                        r_tl    <= w_idle_tl;
                    end
                end
                S_RUN: begin
                    if (w_ev[3]) begin
                        r_state    <= S_DONE;
                        r_tl       <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_tick_cnt <= '0;
                        r_hold     <= '0;
                    end else begin
                        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
                        r_tl       <= w_run_tl;
                        if (w_coin) begin
                            r_money <= w_money_sat;
                        end
                        if (w_run_tl == '0) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_tick_cnt <= '0;
                            r_hold     <= '0;
                        end
                    end
                end
                S_DONE: begin
                    if (w_ev[3]) begin
                        r_state <= S_IDLE;
                        r_money <= '0;
                        r_tl    <= '0;
                        r_done  <= 1'b0;
                        r_hold  <= '0;
                    end else begin
                        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
                        if (w_tick) begin
                            if (r_hold == HW'(DONE_HOLD - 1)) begin
                                r_state <= S_IDLE;
                                r_money <= '0;
                                r_tl    <= '0;
                                r_done  <= 1'b0;
                                r_hold  <= '0;
                            end else begin
                                r_hold <= r_hold + HW'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TimeLeft = {13'b0, r_tl};
    assign bus.Money    = {13'b0, r_money};
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_meter_ctrl.sv
// Directed bench for meter_ctrl with TICK_DIV=4.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_meter_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    meter_ctrl_if mif ();

    meter_ctrl #(
        .TICK_DIV     (4),
        .SEC_PER_UNIT (2),
        .MAX_VAL      (99),
        .DONE_HOLD    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 0:coin1 1:coin5 2:start 3:cancel, high for one clock
    task automatic pulse(input int which);
        case (which)
            0: mif.coin1 = 1'b1;
            1: mif.coin5 = 1'b1;
            2: mif.start = 1'b1;
            default: mif.cancel = 1'b1;
        endcase
        cyc(1);
        mif.coin1  = 1'b0;
        mif.coin5  = 1'b0;
        mif.start  = 1'b0;
        mif.cancel = 1'b0;
    endtask

    initial begin
        mif.coin1  = 1'b0;
        mif.coin5  = 1'b0;
        mif.start  = 1'b0;
        mif.cancel = 1'b0;
        cyc(2);
        rst = 1'b0;
        chk("rst_tl", mif.TimeLeft, 0);
        chk("rst_money", mif.Money, 0);
        chk("rst_busy", 32'(mif.busy), 0);
        chk("rst_done", 32'(mif.done), 0);

        // separate coin pulses in IDLE
        pulse(1); cyc(2);
        chk("c5_money", mif.Money, 5);
        chk("c5_tl", mif.TimeLeft, 10);
        pulse(0); cyc(2);
        chk("c1_money", mif.Money, 6);
        chk("c1_tl", mif.TimeLeft, 12);
        mif.coin1 = 1'b1; cyc(10); mif.coin1 = 1'b0; cyc(2);
        chk("hold_money", mif.Money, 7);
        chk("hold_tl", mif.TimeLeft, 14);
        pulse(3); cyc(2);
        chk("idle_cancel_money", mif.Money, 0);
        chk("idle_cancel_tl", mif.TimeLeft, 0);

        // start with no money is ignored
        pulse(2); cyc(3);
        chk("start0_busy", 32'(mif.busy), 0);
        chk("start0_done", 32'(mif.done), 0);

        // full run: Money=3 -> 6 s, then DONE for 3 s
        pulse(0); cyc(1); pulse(0); cyc(1); pulse(0); cyc(2);
        chk("run_money", mif.Money, 3);
        chk("run_tl0", mif.TimeLeft, 6);
        pulse(2); cyc(1);
        chk("run_busy", 32'(mif.busy), 1);
        chk("run_tl_entry", mif.TimeLeft, 6);
        cyc(3);
        chk("run_tl_e3", mif.TimeLeft, 6);
        cyc(1);
        chk("run_tl_e4", mif.TimeLeft, 5);
        cyc(19);
        chk("run_tl_e23", mif.TimeLeft, 1);
        chk("run_done_e23", 32'(mif.done), 0);
        cyc(1);
        chk("run_tl_e24", mif.TimeLeft, 0);
        chk("run_done_e24", 32'(mif.done), 1);
        chk("run_busy_e24", 32'(mif.busy), 0);
        cyc(11);
        chk("hold_done_d11", 32'(mif.done), 1);
        chk("hold_money_d11", mif.Money, 3);
        cyc(1);
        chk("hold_done_d12", 32'(mif.done), 0);
        chk("hold_money_d12", mif.Money, 0);

        // reset in the middle of RUN
        pulse(1); cyc(2);
        chk("r1_tl", mif.TimeLeft, 10);
        pulse(2); cyc(1);
        chk("r1_busy", 32'(mif.busy), 1);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("r1_rst_tl", mif.TimeLeft, 0);
        chk("r1_rst_money", mif.Money, 0);
        chk("r1_rst_busy", 32'(mif.busy), 0);
        chk("r1_rst_done", 32'(mif.done), 0);

        // saturation in IDLE and on top-up
        for (int i = 0; i < 20; i++) begin
            pulse(1); cyc(1);
        end
        cyc(2);
        chk("sat_money", mif.Money, 99);
        chk("sat_tl", mif.TimeLeft, 99);
        pulse(2); cyc(5);
        chk("sat_run_tl98", mif.TimeLeft, 98);
        pulse(0); cyc(1);
        chk("sat_topup_tl", mif.TimeLeft, 99);
        chk("sat_topup_money", mif.Money, 99);
        rst = 1'b1; cyc(1); rst = 1'b0;

        // coin on a tick edge, then cancel with coin in RUN
        pulse(0); cyc(1); pulse(0); cyc(1); pulse(0); cyc(2);
        pulse(2); cyc(7);
        chk("tc_tl5", mif.TimeLeft, 5);
        pulse(0); cyc(1);
        chk("tc_tl", mif.TimeLeft, 6);
        chk("tc_money", mif.Money, 4);
        mif.cancel = 1'b1;
        mif.coin5  = 1'b1;
        cyc(1);
        mif.cancel = 1'b0;
        mif.coin5  = 1'b0;
        cyc(1);
        chk("cx_done", 32'(mif.done), 1);
        chk("cx_busy", 32'(mif.busy), 0);
        chk("cx_tl", mif.TimeLeft, 0);
        chk("cx_money", mif.Money, 4);
        pulse(3); cyc(1);
        chk("dc_done", 32'(mif.done), 0);
        chk("dc_money", mif.Money, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
